pulse_burst_controller: RTL

// - Runtime-programmable sequencer for pulse generation. Accepts a burst command
//   (pulse duration, pulse period, pulse count) and drives o_pulse through exactly

---
 rtl/pulse_burst_controller.sv | 110 +++++++++++
 1 files changed

// File: rtl/pulse_burst_controller.sv
// Programmable burst sequencer: runs `count` pulses of `duration` high cycles every `period` cycles.
// Optional abort input is compiled in when PULSE_CTRL_ABORT_EN is defined.
module pulse_burst_controller #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [CNT_W-1:0]   i_duration,
    input  logic [CNT_W-1:0]   i_period,
    input  logic [BURST_W-1:0] i_count,
`ifdef PULSE_CTRL_ABORT_EN
    input  logic               i_abort,
`endif
    output logic               o_pulse,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic [BURST_W-1:0] o_pulse_num
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     dur_q, per_q, phase, phase_nxt;
    logic [BURST_W-1:0]   cnt_q, pulse_num;
    logic [BURST_W:0]     num_eff;
    logic                 pulse_q, err_q;
    logic                 cfg_bad, phase_end, last_pulse, abort_req;

    assign cfg_bad   = (i_duration == '0) || (i_period == '0) ||
                       (i_duration > i_period) || (i_count == '0);
    assign phase_end = (phase == per_q - CNT_W'(1));
    assign phase_nxt = phase_end ? '0 : phase + CNT_W'(1);
    // A pulse starting this cycle (phase 0) is already counted here, which
    // keeps period==1 bursts terminating on the right cycle.
    assign num_eff    = {1'b0, pulse_num} + (BURST_W+1)'(phase == '0);
    assign last_pulse = (num_eff >= {1'b0, cnt_q});

`ifdef PULSE_CTRL_ABORT_EN
    assign abort_req = i_abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_start && !cfg_bad) state_nxt = RUN;
            RUN:  if (abort_req || (phase_end && last_pulse)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dur_q     <= '0;
            per_q     <= '0;
            cnt_q     <= '0;
            phase     <= '0;
            pulse_num <= '0;
            pulse_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q   <= 1'b0;
            pulse_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        if (cfg_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            dur_q     <= i_duration;
                            per_q     <= i_period;
                            cnt_q     <= i_count;
                            phase     <= '0;
                            pulse_num <= '0;
                            pulse_q   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (phase == '0 && pulse_num < cnt_q)
                        pulse_num <= pulse_num + BURST_W'(1);
                    if (state_nxt == RUN) begin
                        phase   <= phase_nxt;
                        pulse_q <= (phase_nxt < dur_q);
                    end else begin
                        phase   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_pulse     = pulse_q;
    assign o_busy      = (state == RUN);
    assign o_done      = (state == DONE);
    assign o_err       = err_q;
    assign o_pulse_num = pulse_num;

endmodule
